// File: rtl/fu_pipe_unit.sv
// Pipelined multiply unit: fixed-latency stages feeding a FWFT result FIFO,
// with credit-based issue control and a per-register pending scoreboard.
module fu_pipe_unit #(
   parameter int DBITS  = 32,
   parameter int NREGS  = 32,
   parameter int LAT    = 3,
   parameter int ODEPTH = 4,
   localparam int RW    = $clog2(NREGS),
   localparam int CW    = $clog2(ODEPTH + 1),
   localparam int PW    = $clog2(ODEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [DBITS-1:0] in_a,
   input  logic [DBITS-1:0] in_b,
   input  logic [RW-1:0]    in_rd,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DBITS-1:0] out_data,
   output logic [RW-1:0]    out_rd,
   input  logic [RW-1:0]    q_rs1,
   input  logic [RW-1:0]    q_rs2,
   output logic             q_hazard,
   output logic [CW-1:0]    busy_cnt
);

   logic                  accept, pop, wr_en;
   logic                  a_sx, b_sx;
   logic signed [DBITS:0] a_ext, b_ext;
   logic signed [2*DBITS-1:0] prod;
   logic [DBITS-1:0]      result;

   logic                  stage_valid_reg [LAT];
   logic [DBITS-1:0]      stage_data_reg  [LAT];
   logic [RW-1:0]         stage_rd_reg    [LAT];

   logic [DBITS-1:0]      mem_data [ODEPTH];
   logic [RW-1:0]         mem_rd   [ODEPTH];
   logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]         count_reg, busy_cnt_reg;
   logic [CW-1:0]         pending_reg [NREGS];

   assign in_ready  = (busy_cnt_reg < CW'(ODEPTH)) && !flush && !reset;
   assign accept    = in_valid && in_ready;
   assign out_valid = !reset && (count_reg != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_data[rd_ptr_reg] : '0;
   assign out_rd    = out_valid ? mem_rd[rd_ptr_reg] : '0;
   assign busy_cnt  = reset ? '0 : busy_cnt_reg;
   assign wr_en     = stage_valid_reg[LAT-1];

   // One extra sign/zero bit per operand lets a single signed multiply cover all four ops.
   always_comb begin
      a_sx   = ((in_op == 2'd1) || (in_op == 2'd2)) && in_a[DBITS-1];
      b_sx   = (in_op == 2'd1) && in_b[DBITS-1];
      a_ext  = {a_sx, in_a};
      b_ext  = {b_sx, in_b};
      prod   = a_ext * b_ext;
      result = (in_op == 2'd0) ? prod[DBITS-1:0] : prod[2*DBITS-1:DBITS];
   end

   generate
      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (reset || flush) begin
               stage_valid_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
               stage_valid_reg[gi] <= accept;
            end else begin
               stage_valid_reg[gi] <= stage_valid_reg[(gi > 0) ? gi - 1 : 0];
            end
         end
         always_ff @(posedge clk) begin
            if (gi == 0) begin
               stage_data_reg[gi] <= result;
               stage_rd_reg[gi]   <= in_rd;
            end else begin
               stage_data_reg[gi] <= stage_data_reg[(gi > 0) ? gi - 1 : 0];
               stage_rd_reg[gi]   <= stage_rd_reg[(gi > 0) ? gi - 1 : 0];
            end
         end
      end
   endgenerate

   // Credits cap in-flight plus buffered ops at ODEPTH, so the FIFO cannot overflow.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr_reg] <= stage_data_reg[LAT-1];
         mem_rd[wr_ptr_reg]   <= stage_rd_reg[LAT-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         busy_cnt_reg <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (wr_en && !pop)      count_reg <= count_reg + CW'(1);
         else if (!wr_en && pop) count_reg <= count_reg - CW'(1);
         if (accept && !pop)      busy_cnt_reg <= busy_cnt_reg + CW'(1);
         else if (!accept && pop) busy_cnt_reg <= busy_cnt_reg - CW'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
         logic inc, dec;
         assign inc = (gi != 0) && accept && (in_rd == RW'(gi));
         assign dec = (gi != 0) && pop && (out_rd == RW'(gi));
         always_ff @(posedge clk) begin
            if (reset || flush)   pending_reg[gi] <= '0;
            else if (inc && !dec) pending_reg[gi] <= pending_reg[gi] + CW'(1);
            else if (dec && !inc) pending_reg[gi] <= pending_reg[gi] - CW'(1);
         end
      end
   endgenerate

   assign q_hazard = !reset &&
                     (((q_rs1 != '0) && (pending_reg[q_rs1] != '0)) ||
                      ((q_rs2 != '0) && (pending_reg[q_rs2] != '0)));

endmodule
